// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch front end.
//   fetch_data        : {pc, instr} pair carried through the fetch FIFO to decode
//   RESET_PC_DEFAULT  : default PC loaded at reset
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch unit's bus signals: redirect input, instruction-memory
// request/response, and the valid/ready stream toward decode.
//   master : the fetch unit side
//   slave  : the environment (branch unit, imem, decode skid buffer)
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          imem_req_valid;
    logic [31:0]   imem_req_addr;
    logic          imem_resp_valid;
    logic [31:0]   imem_resp_instr;
    logic          valid_out;
    logic          ready_out;
    fetch_data     data_out;
    logic [CW-1:0] count;

    modport master (
        input  redirect_valid, redirect_pc, imem_resp_valid, imem_resp_instr, ready_out,
        output imem_req_valid, imem_req_addr, valid_out, data_out, count
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_resp_valid, imem_resp_instr, ready_out,
        input  imem_req_valid, imem_req_addr, valid_out, data_out, count
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions.
//   clk, reset : core clock, synchronous active-low reset
//   push, din  : write din at the tail
//   pop        : advance the head (ignored when empty)
//   flush      : drop all entries next cycle (overrides push/pop)
//   dout       : head entry, combinational
//   count      : occupied entries, 0..DEPTH
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter type T     = fetch_data,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         din,
    output T                         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);
    assign dout   = mem[rptr];

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)   wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            if (push && !do_pop)      count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; count gates whether the head is meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues one request per cycle to a 1-cycle
// instruction memory while credit allows, and buffers responses for decode.
//   clk    : core clock
//   reset  : synchronous active-low reset
//   bus    : fetch_queue_if.master (redirect, imem req/resp, decode stream, count)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          kill;
    logic [CW-1:0] fcount;
    logic          req_valid;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    fetch_data     wdata;
    fetch_data     head;

    // Credit counts the in-flight slot as occupied; a same-cycle pop does not
    // free a slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, fcount} + {{CW{1'b0}}, inflight};
    assign req_valid = reset && !bus.redirect_valid && (occupancy < DEPTH_W);

    assign push  = bus.imem_resp_valid && inflight && !kill;
    assign pop   = (fcount != '0) && bus.ready_out;
    assign wdata = '{pc: req_pc, instr: bus.imem_resp_instr};

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.valid_out      = (fcount != '0);
    assign bus.data_out       = head;
    assign bus.count          = fcount;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else if (bus.redirect_valid) begin
            // No request goes out this cycle; anything still returning is stale.
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
            kill     <= inflight;
        end else begin
            kill     <= 1'b0;
            inflight <= req_valid;
            if (req_valid) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .T     (fetch_data),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (wdata),
        .dout  (head),
        .count (fcount)
    );

endmodule
